// File: rtl/bus_arbiter4_if.sv
// Handshake bundle between four requesters, the shared resource and the round-robin arbiter.
// master = requester/resource side (drives req, done); slave = arbiter side (drives grant outputs).
interface bus_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       start;
    logic       busy;
    logic       abort;
    logic [1:0] err_id;

    modport master (
        output req, done,
        input  s, gnt, start, busy, abort, err_id
    );

    modport slave (
        input  req, done,
        output s, gnt, start, busy, abort, err_id
    );
endinterface

// File: rtl/bus_arbiter4.sv
// Round-robin 4-way arbiter for one shared datapath port; grant registered one edge after req in IDLE.
// No backpressure: a grant is held until done, grantee withdrawal or the MAX_HOLD watchdog.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter4_if.slave  bus
);

    localparam int             CW   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [1:0]     s_nxt;
    logic [3:0]     gnt_nxt;
    logic           start_nxt;
    logic           busy_nxt;
    logic           abort_nxt;
    logic [1:0]     err_nxt;
    logic [1:0]     win;

    // First set request bit scanning from the priority pointer upward, modulo 4.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] from);
        logic [1:0] w;
        logic [1:0] idx;
        logic       found;
        w     = from;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = from + 2'(i);
            if (!found && req[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign win = pick_winner(bus.req, ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        s_nxt     = bus.s;
        gnt_nxt   = bus.gnt;
        start_nxt = 1'b0;
        busy_nxt  = bus.busy;
        abort_nxt = 1'b0;
        err_nxt   = bus.err_id;

        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_nxt = ACTIVE;
                    s_nxt     = win;
                    gnt_nxt   = 4'b0001 << win;
                    start_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                // done outranks both withdrawal and expiry, so a late done never raises abort
                if (bus.done || !bus.req[bus.s] || (cnt == LAST)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = bus.s + 2'd1;
                    cnt_nxt   = '0;
                    if (!bus.done && bus.req[bus.s]) begin
                        abort_nxt = 1'b1;
                        err_nxt   = bus.s;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 2'd0;
            cnt        <= '0;
            bus.s      <= 2'd0;
            bus.gnt    <= 4'b0000;
            bus.start  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.abort  <= 1'b0;
            bus.err_id <= 2'd0;
        end else begin
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            bus.s      <= s_nxt;
            bus.gnt    <= gnt_nxt;
            bus.start  <= start_nxt;
            bus.busy   <= busy_nxt;
            bus.abort  <= abort_nxt;
            bus.err_id <= err_nxt;
        end
    end

    a_gnt_matches_sel: assert property (@(posedge clk) disable iff (!rst_n)
        bus.busy |-> (bus.gnt == (4'b0001 << bus.s)));
    a_gnt_zero_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.busy |-> (bus.gnt == 4'b0000));
    a_start_in_active: assert property (@(posedge clk) disable iff (!rst_n)
        bus.start |-> bus.busy);
    a_abort_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.abort |-> !bus.busy);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed request/done vectors, a transaction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_bus_arbiter4;

    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    bus_arbiter4_if bus ();

    bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the port, for how long, and where priority starts next.
    int m_owner;
    int m_age;
    int m_ptr;
    int m_s;
    int m_err;
    bit m_start;
    bit m_abort;
    int cand;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_s = 0; m_err = 0;
            m_start = 0;  m_abort = 0;
        end else begin
            m_start = 0;
            m_abort = 0;
            if (m_owner < 0) begin
                if (bus.req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        cand = (m_ptr + k) % 4;
                        if (m_owner < 0 && bus.req[cand]) m_owner = cand;
                    end
                    m_s     = m_owner;
                    m_age   = 0;
                    m_start = 1;
                end
            end else begin
                m_age = m_age + 1;
                if (bus.done || !bus.req[m_owner] || m_age == MAX_HOLD) begin
                    if (!bus.done && bus.req[m_owner]) begin
                        m_abort = 1;
                        m_err   = m_owner;
                    end
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end
            end
        end
    end

    logic [1:0] e_s, e_err;
    logic [3:0] e_gnt;
    logic       e_busy;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            e_s    = 2'(m_s);
            e_err  = 2'(m_err);
            e_gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            e_busy = (m_owner >= 0);
            checks++;
            if ({bus.s, bus.gnt, bus.start, bus.busy, bus.abort, bus.err_id} !==
                {e_s, e_gnt, m_start, e_busy, m_abort, e_err}) begin
                failures++;
                $display("FAIL model_cycle t=%0t: got s=%0d gnt=%b start=%b busy=%b abort=%b err_id=%0d, expected s=%0d gnt=%b start=%b busy=%b abort=%b err_id=%0d",
                         $time, bus.s, bus.gnt, bus.start, bus.busy, bus.abort, bus.err_id,
                         e_s, e_gnt, m_start, e_busy, m_abort, e_err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s"},      32'(bus.s),      0);
        chk({tag, "_gnt"},    32'(bus.gnt),    0);
        chk({tag, "_start"},  32'(bus.start),  0);
        chk({tag, "_busy"},   32'(bus.busy),   0);
        chk({tag, "_abort"},  32'(bus.abort),  0);
        chk({tag, "_err_id"}, 32'(bus.err_id), 0);
    endtask

    int n;
    int nb;
    int na;
    int order [8];

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single request, done in ACTIVE cycle 3
        bus.req = 4'b0100;
        @(negedge clk);
        chk("single_s",     32'(bus.s),     2);
        chk("single_gnt",   32'(bus.gnt),   4);
        chk("single_start", 32'(bus.start), 1);
        chk("single_busy",  32'(bus.busy),  1);
        @(negedge clk);
        chk("single_start_c1", 32'(bus.start), 0);
        repeat (2) @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        chk("single_done_gnt",  32'(bus.gnt),  0);
        chk("single_done_busy", 32'(bus.busy), 0);

        // pointer now 3: 0101 scans 3,0 and picks 0
        bus.req = 4'b0101;
        @(negedge clk);
        chk("ptr3_pick", 32'(bus.s), 0);
        bus.done = 1'b1;
        @(negedge clk);

        // all requesting, done in every cycle 0: pointer starts at 1
        bus.req  = 4'b1111;
        bus.done = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.start) begin
                if (n < 8) order[n] = 32'(bus.s);
                n++;
            end
        end
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        chk("rr_grants", n, 5);
        chk("rr_0", order[0], 1);
        chk("rr_1", order[1], 2);
        chk("rr_2", order[2], 3);
        chk("rr_3", order[3], 0);
        chk("rr_4", order[4], 1);

        // watchdog on requester 1, no done
        bus.req = 4'b0010;
        nb = 0;
        na = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy) nb++;
            if (bus.abort) begin
                na++;
                chk("wd_gnt",    32'(bus.gnt),    0);
                chk("wd_err_id", 32'(bus.err_id), 1);
                bus.req = 4'b0000;
            end
        end
        chk("wd_busy_cycles",  nb, MAX_HOLD);
        chk("wd_abort_pulses", na, 1);

        // pointer 2 wraps: 0011 picks 0; then withdrawal in cycle 5
        bus.req = 4'b0011;
        @(negedge clk);
        chk("wd_next_pick", 32'(bus.s), 0);
        repeat (5) @(negedge clk);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("wdraw_gnt",    32'(bus.gnt),    0);
        chk("wdraw_abort",  32'(bus.abort),  0);
        chk("wdraw_err_id", 32'(bus.err_id), 1);

        // done coincident with the last watchdog cycle on requester 3
        bus.req = 4'b1000;
        @(negedge clk);
        chk("coin_pick", 32'(bus.s), 3);
        repeat (MAX_HOLD - 1) @(negedge clk);
        chk("coin_busy_last", 32'(bus.busy), 1);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        chk("coin_abort",  32'(bus.abort),  0);
        chk("coin_err_id", 32'(bus.err_id), 1);
        chk("coin_busy",   32'(bus.busy),   0);

        // move pointer to 1, then reset mid-grant of requester 2
        bus.req = 4'b0001;
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.req  = 4'b0100;
        @(negedge clk);
        chk("pre_rst_pick", 32'(bus.s), 2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        bus.req = 4'b1001;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("post_rst_pick",  32'(bus.s),     0);
        chk("post_rst_start", 32'(bus.start), 1);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;

        // pointer 1: 0100 picks 2, then spurious done while idle
        bus.req = 4'b0100;
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        chk("spur_s",     32'(bus.s),     2);
        chk("spur_gnt",   32'(bus.gnt),   0);
        chk("spur_start", 32'(bus.start), 0);
        chk("spur_abort", 32'(bus.abort), 0);
        bus.req = 4'b1100;
        @(negedge clk);
        chk("spur_ptr_pick", 32'(bus.s), 3);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
